dual_queue_ctrl: RTL

- Control stage directly upstream of the dual-port queue memory.
- Converts a valid/ready producer stream and a ready-driven consumer into the memory's write enable, write and read addresses, and write data.
- Owns the write/read pointers, the occupancy count and the empty/full/almost-full flags, so the memory itself stays a plain storage array.

---
 rtl/queue_pkg.sv | 18 +
 rtl/queue_ptr.sv | 30 +++
 rtl/dual_queue_ctrl.sv | 72 +++++++
 3 files changed

// File: rtl/queue_pkg.sv
// Shared types and defaults for the dual-port queue controller, its memory and its bench.
package queue_pkg;

    localparam int Q_DATA_W    = 4;
    localparam int Q_ADDR_W    = 3;
    localparam int Q_AFULL_LVL = 6;
    localparam int Q_DEPTH     = 2 ** Q_ADDR_W;

    typedef logic [Q_ADDR_W:0]   ptr_t;
    typedef logic [Q_ADDR_W-1:0] addr_t;
    typedef logic [Q_DATA_W-1:0] data_t;

    // Wrap-bit arithmetic: the subtraction modulo 2**(ADDR_W+1) is the occupancy.
    function automatic ptr_t occ(input ptr_t wr, input ptr_t rd);
        return wr - rd;
    endfunction

endpackage

// File: rtl/queue_ptr.sv
// Wrap-bit queue pointer: low bits address the memory, the MSB toggles on each lap.
module queue_ptr #(
    parameter int ADDR_W = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    input  logic          load,
    input  logic [ADDR_W:0] load_val,
    output logic [ADDR_W:0] ptr
);

    logic [ADDR_W:0] ptr_r;

    // Pointer register: reset beats load, load beats increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r <= '0;
        end else if (load) begin
            ptr_r <= load_val;
        end else if (inc) begin
            ptr_r <= ptr_r + {{ADDR_W{1'b0}}, 1'b1};
        end else begin
            ptr_r <= ptr_r;
        end
    end

    assign ptr = ptr_r;

endmodule

// File: rtl/dual_queue_ctrl.sv
// Pointer and flag control for a show-ahead queue built on an async-read dual-port memory.
module dual_queue_ctrl
    import queue_pkg::*;
#(
    parameter int DATA_W    = Q_DATA_W,
    parameter int ADDR_W    = Q_ADDR_W,
    parameter int AFULL_LVL = Q_AFULL_LVL
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              out_ready,
    output logic              out_valid,
    output logic              we_dual,
    output logic [ADDR_W-1:0] addr_wr,
    output logic [ADDR_W-1:0] addr_rd,
    output logic [DATA_W-1:0] din,
    output logic              dual_empty,
    output logic              dual_full,
    output logic              almost_full,
    output logic [ADDR_W:0]   fifo_cnt
);

    logic [ADDR_W:0] wr_ptr_s;
    logic [ADDR_W:0] rd_ptr_s;
    logic            empty_s;
    logic            full_s;
    logic            push_s;
    logic            pop_s;

    // Flags come only from the registered pointers, never from the handshake inputs.
    assign empty_s     = (wr_ptr_s == rd_ptr_s);
    assign full_s      = (wr_ptr_s[ADDR_W] != rd_ptr_s[ADDR_W]) &&
                         (wr_ptr_s[ADDR_W-1:0] == rd_ptr_s[ADDR_W-1:0]);
    assign fifo_cnt    = occ(wr_ptr_s, rd_ptr_s);
    assign almost_full = (fifo_cnt >= (ADDR_W+1)'(AFULL_LVL));
    assign dual_empty  = empty_s;
    assign dual_full   = full_s;
    assign in_ready    = ~full_s;
    assign out_valid   = ~empty_s;

    // A full queue refuses the write even when a pop frees a slot in the same cycle.
    assign push_s  = in_valid & ~full_s & ~flush & ~rst;
    assign pop_s   = out_ready & ~empty_s & ~flush & ~rst;
    assign we_dual = push_s;
    assign din     = in_data;
    assign addr_wr = wr_ptr_s[ADDR_W-1:0];
    assign addr_rd = rd_ptr_s[ADDR_W-1:0];

    queue_ptr #(.ADDR_W(ADDR_W)) u_wr_ptr (
        .clk      (clk),
        .rst      (rst),
        .inc      (push_s),
        .load     (1'b0),
        .load_val ({(ADDR_W+1){1'b0}}),
        .ptr      (wr_ptr_s)
    );

    // Flush discards contents by snapping the read pointer onto the write pointer.
    queue_ptr #(.ADDR_W(ADDR_W)) u_rd_ptr (
        .clk      (clk),
        .rst      (rst),
        .inc      (pop_s),
        .load     (flush),
        .load_val (wr_ptr_s),
        .ptr      (rd_ptr_s)
    );

endmodule
